mouse_position_tracker: RTL and testbench

MOUSE_POSITION_TRACKER -- requirements
Module: mouse_position_tracker

---
 rtl/mouse_pkg.sv | 38 +++
 rtl/mouse_axis_accum.sv | 73 +++++++
 rtl/mouse_position_tracker.sv | 259 +++++++++++++++++++++++++
 tb/tb_mouse_position_tracker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker.
//   state_e     : packet-processing FSM states
//   STAT_*      : bit positions inside the PS/2 status byte
//   Z_WIDTH     : wheel accumulator width
//   sat_add_z   : saturating two's-complement add for the wheel accumulator
package mouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_CLAMP   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_e;

    localparam int unsigned STAT_BTN_L = 0;
    localparam int unsigned STAT_BTN_R = 1;
    localparam int unsigned STAT_BTN_M = 2;
    localparam int unsigned STAT_SYNC  = 3;
    localparam int unsigned STAT_XSIGN = 4;
    localparam int unsigned STAT_YSIGN = 5;
    localparam int unsigned STAT_XOVF  = 6;
    localparam int unsigned STAT_YOVF  = 7;

    localparam int unsigned Z_WIDTH = 8;

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    function automatic logic [Z_WIDTH-1:0] sat_add_z(input logic [Z_WIDTH-1:0] acc,
                                                     input logic [Z_WIDTH-1:0] delta);
        logic signed [Z_WIDTH:0] sum;
        sum = (Z_WIDTH+1)'(signed'(acc)) + (Z_WIDTH+1)'(signed'(delta));
        if (sum[Z_WIDTH] != sum[Z_WIDTH-1]) begin
            sat_add_z = sum[Z_WIDTH] ? {1'b1, {(Z_WIDTH-1){1'b0}}} : {1'b0, {(Z_WIDTH-1){1'b1}}};
        end else begin
            sat_add_z = sum[Z_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One movement axis: sign-extends a 9-bit PS/2 delta, adds it to (or subtracts
// it from) the current position, then clamps into 0..LIMIT-1.
//   CLK, RESET  : clock, async active-high reset
//   calc_en_i   : register the unclamped sum
//   clamp_en_i  : register the clamped result
//   pos_i       : current absolute position
//   mag_i       : low 8 bits of the delta
//   sign_i      : delta sign bit (9th bit)
//   ovf_i       : overflow flag; forces the delta to zero
//   pos_o       : clamped candidate position
module mouse_axis_accum #(
    parameter int unsigned POS_WIDTH = 8,
    parameter int unsigned LIMIT     = 160,
    parameter bit          SUBTRACT  = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 calc_en_i,
    input  logic                 clamp_en_i,
    input  logic [POS_WIDTH-1:0] pos_i,
    input  logic [7:0]           mag_i,
    input  logic                 sign_i,
    input  logic                 ovf_i,
    output logic [POS_WIDTH-1:0] pos_o
);

    // Two extra bits cover the full -256..(2^POS_WIDTH-1)+255 range of the sum.
    localparam int unsigned SW = POS_WIDTH + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(LIMIT - 1);

    logic signed [8:0]    delta9;
    logic signed [SW-1:0] delta_ext;
    logic signed [SW-1:0] pos_ext;
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;
    logic [POS_WIDTH-1:0] clamp_d;
    logic [POS_WIDTH-1:0] clamp_q;

    // Unclamped new position
    always_comb begin
        delta9    = ovf_i ? 9'sd0 : signed'({sign_i, mag_i});
        delta_ext = SW'(delta9);
        pos_ext   = signed'(SW'(pos_i));
        sum_d     = SUBTRACT ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
    end

    // Clamp into the legal window
    always_comb begin
        clamp_d = sum_q[POS_WIDTH-1:0];
        if (sum_q[SW-1]) begin
            clamp_d = '0;
        end else if (sum_q > MAX_S) begin
            clamp_d = POS_WIDTH'(LIMIT - 1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sum_q   <= '0;
            clamp_q <= '0;
        end else begin
            if (calc_en_i) begin
                sum_q <= sum_d;
            end
            if (clamp_en_i) begin
                clamp_q <= clamp_d;
            end
        end
    end

    assign pos_o = clamp_q;

endmodule

// File: rtl/mouse_position_tracker.sv
// Converts decoded PS/2 mouse packets into a clamped absolute screen position.
// Optional wheel accumulation is enabled by defining MOUSE_POS_WHEEL_EN.
//   CLK, RESET   : clock, async active-high reset
//   PKT_VALID    : strobe, packet bytes valid
//   STATUS_BYTE  : buttons, sync bit, sign and overflow flags
//   DX/DY/DZ_BYTE: movement bytes
//   RECENTER     : abort in-flight packet and return to the start position
//   CLR_FLAGS    : clear sticky OVERRUN / SYNC_ERR
//   POS_X/POS_Y  : absolute position (Y: 0 = top)
//   POS_Z        : wheel accumulator (0 when wheel support is compiled out)
//   BUTTONS      : {M,R,L} of the last accepted packet
//   POS_VALID    : one-cycle pulse when outputs update
//   BUSY         : packet in flight
//   OVERRUN      : sticky, packet arrived while BUSY
//   SYNC_ERR     : sticky, packet rejected for a clear sync bit
module mouse_position_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned POS_WIDTH = 8,
    parameter int unsigned LIMIT_X   = 160,
    parameter int unsigned LIMIT_Y   = 120,
    parameter int unsigned START_X   = 80,
    parameter int unsigned START_Y   = 60
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 PKT_VALID,
    input  logic [7:0]           STATUS_BYTE,
    input  logic [7:0]           DX_BYTE,
    input  logic [7:0]           DY_BYTE,
    input  logic [7:0]           DZ_BYTE,
    input  logic                 RECENTER,
    input  logic                 CLR_FLAGS,
    output logic [POS_WIDTH-1:0] POS_X,
    output logic [POS_WIDTH-1:0] POS_Y,
    output logic [Z_WIDTH-1:0]   POS_Z,
    output logic [2:0]           BUTTONS,
    output logic                 POS_VALID,
    output logic                 BUSY,
    output logic                 OVERRUN,
    output logic                 SYNC_ERR
);

    // Parameter legality
    if (POS_WIDTH < 8 || POS_WIDTH > 30) begin : g_bad_width
        $error("POS_WIDTH must be in 8..30");
    end
    if (LIMIT_X == 0 || LIMIT_X > (1 << POS_WIDTH)) begin : g_bad_limit_x
        $error("LIMIT_X out of range for POS_WIDTH");
    end
    if (LIMIT_Y == 0 || LIMIT_Y > (1 << POS_WIDTH)) begin : g_bad_limit_y
        $error("LIMIT_Y out of range for POS_WIDTH");
    end
    if (START_X >= LIMIT_X) begin : g_bad_start_x
        $error("START_X must be below LIMIT_X");
    end
    if (START_Y >= LIMIT_Y) begin : g_bad_start_y
        $error("START_Y must be below LIMIT_Y");
    end

    state_e state_q;
    state_e state_d;

    logic busy_c;
    logic accept_c;
    logic sync_bad_c;
    logic overrun_set_c;
    logic calc_en_c;
    logic clamp_en_c;
    logic publish_c;

    logic [2:0]           btn_q;
    logic                 xsign_q;
    logic                 ysign_q;
    logic                 xovf_q;
    logic                 yovf_q;
    logic [7:0]           dx_q;
    logic [7:0]           dy_q;
    logic [POS_WIDTH-1:0] axis_x;
    logic [POS_WIDTH-1:0] axis_y;

    logic [POS_WIDTH-1:0] pos_x_q;
    logic [POS_WIDTH-1:0] pos_y_q;
    logic [Z_WIDTH-1:0]   pos_z_q;
    logic [2:0]           buttons_q;
    logic                 pos_valid_q;
    logic                 overrun_q;
    logic                 overrun_d;
    logic                 sync_err_q;
    logic                 sync_err_d;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; RECENTER aborts from anywhere
    always_comb begin
        state_d = state_q;
        if (RECENTER) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if (PKT_VALID && STATUS_BYTE[STAT_SYNC]) state_d = ST_CALC;
                ST_CALC:    state_d = ST_CLAMP;
                ST_CLAMP:   state_d = ST_PUBLISH;
                ST_PUBLISH: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // FSM decodes
    always_comb begin
        busy_c        = (state_q != ST_IDLE);
        accept_c      = 1'b0;
        sync_bad_c    = 1'b0;
        overrun_set_c = 1'b0;
        calc_en_c     = 1'b0;
        clamp_en_c    = 1'b0;
        publish_c     = 1'b0;
        if (!RECENTER) begin
            accept_c      = !busy_c && PKT_VALID && STATUS_BYTE[STAT_SYNC];
            sync_bad_c    = !busy_c && PKT_VALID && !STATUS_BYTE[STAT_SYNC];
            overrun_set_c = busy_c && PKT_VALID;
            calc_en_c     = (state_q == ST_CALC);
            clamp_en_c    = (state_q == ST_CLAMP);
            publish_c     = (state_q == ST_PUBLISH);
        end
    end

    // Sticky flags; a same-cycle set beats CLR_FLAGS
    always_comb begin
        overrun_d  = overrun_q;
        sync_err_d = sync_err_q;
        if (CLR_FLAGS) begin
            overrun_d  = 1'b0;
            sync_err_d = 1'b0;
        end
        if (overrun_set_c) begin
            overrun_d = 1'b1;
        end
        if (sync_bad_c) begin
            sync_err_d = 1'b1;
        end
    end

    // Packet capture
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_q   <= '0;
            xsign_q <= 1'b0;
            ysign_q <= 1'b0;
            xovf_q  <= 1'b0;
            yovf_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else if (accept_c) begin
            btn_q   <= {STATUS_BYTE[STAT_BTN_M], STATUS_BYTE[STAT_BTN_R], STATUS_BYTE[STAT_BTN_L]};
            xsign_q <= STATUS_BYTE[STAT_XSIGN];
            ysign_q <= STATUS_BYTE[STAT_YSIGN];
            xovf_q  <= STATUS_BYTE[STAT_XOVF];
            yovf_q  <= STATUS_BYTE[STAT_YOVF];
            dx_q    <= DX_BYTE;
            dy_q    <= DY_BYTE;
        end
    end

    mouse_axis_accum #(
        .POS_WIDTH (POS_WIDTH),
        .LIMIT     (LIMIT_X),
        .SUBTRACT  (1'b0)
    ) u_axis_x (
        .CLK        (CLK),
        .RESET      (RESET),
        .calc_en_i  (calc_en_c),
        .clamp_en_i (clamp_en_c),
        .pos_i      (pos_x_q),
        .mag_i      (dx_q),
        .sign_i     (xsign_q),
        .ovf_i      (xovf_q),
        .pos_o      (axis_x)
    );

    // PS/2 Y is positive-up, the screen is positive-down
    mouse_axis_accum #(
        .POS_WIDTH (POS_WIDTH),
        .LIMIT     (LIMIT_Y),
        .SUBTRACT  (1'b1)
    ) u_axis_y (
        .CLK        (CLK),
        .RESET      (RESET),
        .calc_en_i  (calc_en_c),
        .clamp_en_i (clamp_en_c),
        .pos_i      (pos_y_q),
        .mag_i      (dy_q),
        .sign_i     (ysign_q),
        .ovf_i      (yovf_q),
        .pos_o      (axis_y)
    );

`ifdef MOUSE_POS_WHEEL_EN
    logic [7:0] dz_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dz_q <= '0;
        end else if (accept_c) begin
            dz_q <= DZ_BYTE;
        end
    end
`else
    logic unused_dz;
    assign unused_dz = ^DZ_BYTE;
`endif

    // Published outputs and flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pos_x_q     <= POS_WIDTH'(START_X);
            pos_y_q     <= POS_WIDTH'(START_Y);
            pos_z_q     <= '0;
            buttons_q   <= '0;
            pos_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            pos_valid_q <= publish_c;
            overrun_q   <= overrun_d;
            sync_err_q  <= sync_err_d;
            if (RECENTER) begin
                pos_x_q <= POS_WIDTH'(START_X);
                pos_y_q <= POS_WIDTH'(START_Y);
                pos_z_q <= '0;
            end else if (publish_c) begin
                pos_x_q   <= axis_x;
                pos_y_q   <= axis_y;
                buttons_q <= btn_q;
`ifdef MOUSE_POS_WHEEL_EN
                pos_z_q   <= sat_add_z(pos_z_q, dz_q);
`endif
            end
        end
    end

    assign POS_X     = pos_x_q;
    assign POS_Y     = pos_y_q;
    assign POS_Z     = pos_z_q;
    assign BUTTONS   = buttons_q;
    assign POS_VALID = pos_valid_q;
    assign BUSY      = busy_c;
    assign OVERRUN   = overrun_q;
    assign SYNC_ERR  = sync_err_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Self-checking bench for mouse_position_tracker: directed scenarios plus
// randomized packets compared against an arithmetic reference model.
// Wheel expectations follow MOUSE_POS_WHEEL_EN.
module tb_mouse_position_tracker;

    localparam int LX = 160;
    localparam int LY = 120;
    localparam int SX = 80;
    localparam int SY = 60;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       PKT_VALID = 1'b0;
    logic [7:0] STATUS_BYTE = '0;
    logic [7:0] DX_BYTE = '0;
    logic [7:0] DY_BYTE = '0;
    logic [7:0] DZ_BYTE = '0;
    logic       RECENTER = 1'b0;
    logic       CLR_FLAGS = 1'b0;
    logic [7:0] POS_X;
    logic [7:0] POS_Y;
    logic [7:0] POS_Z;
    logic [2:0] BUTTONS;
    logic       POS_VALID;
    logic       BUSY;
    logic       OVERRUN;
    logic       SYNC_ERR;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int mx, my, mz, mbtn;

    mouse_position_tracker dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PKT_VALID   (PKT_VALID),
        .STATUS_BYTE (STATUS_BYTE),
        .DX_BYTE     (DX_BYTE),
        .DY_BYTE     (DY_BYTE),
        .DZ_BYTE     (DZ_BYTE),
        .RECENTER    (RECENTER),
        .CLR_FLAGS   (CLR_FLAGS),
        .POS_X       (POS_X),
        .POS_Y       (POS_Y),
        .POS_Z       (POS_Z),
        .BUTTONS     (BUTTONS),
        .POS_VALID   (POS_VALID),
        .BUSY        (BUSY),
        .OVERRUN     (OVERRUN),
        .SYNC_ERR    (SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int clampv(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim - 1) return lim - 1;
        return v;
    endfunction

    function automatic int axis_delta(input logic [7:0] mag, input bit sgn, input bit ovf);
        if (ovf) return 0;
        return sgn ? int'(mag) - 256 : int'(mag);
    endfunction

    task automatic model_recenter();
        mx = SX;
        my = SY;
        mz = 0;
    endtask

    task automatic model_apply(input logic [7:0] st, input logic [7:0] dx,
                               input logic [7:0] dy, input logic [7:0] dz);
        mx   = clampv(mx + axis_delta(dx, st[4], st[6]), LX);
        my   = clampv(my - axis_delta(dy, st[5], st[7]), LY);
        mbtn = int'(st[2:0]);
`ifdef MOUSE_POS_WHEEL_EN
        mz = mz + int'($signed(dz));
        if (mz > 127) mz = 127;
        if (mz < -128) mz = -128;
`else
        if (dz == 8'hxx) mz = 0;
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_x"}, int'(POS_X), mx);
        check({tag, "_y"}, int'(POS_Y), my);
        check({tag, "_z"}, int'($signed(POS_Z)), mz);
        check({tag, "_btn"}, int'(BUTTONS), mbtn);
    endtask

    // Count POS_VALID pulses over n cycles
    task automatic count_pv(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (POS_VALID) cnt++;
        end
    endtask

    task automatic drive_pkt(input logic [7:0] st, input logic [7:0] dx,
                             input logic [7:0] dy, input logic [7:0] dz);
        PKT_VALID   = 1'b1;
        STATUS_BYTE = st;
        DX_BYTE     = dx;
        DY_BYTE     = dy;
        DZ_BYTE     = dz;
    endtask

    // Send one packet from IDLE and check the result against the model
    task automatic send_pkt(input string tag, input logic [7:0] st, input logic [7:0] dx,
                            input logic [7:0] dy, input logic [7:0] dz);
        int lat;
        int cnt;
        drive_pkt(st, dx, dy, dz);
        tick();
        PKT_VALID = 1'b0;
        if (st[3]) begin
            check({tag, "_busy"}, int'(BUSY), 1);
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (POS_VALID) begin
                    lat = k;
                    break;
                end
            end
            check({tag, "_lat"}, lat, 3);
            model_apply(st, dx, dy, dz);
            check_outputs(tag);
            check({tag, "_idle"}, int'(BUSY), 0);
        end else begin
            check({tag, "_busy"}, int'(BUSY), 0);
            check({tag, "_serr"}, int'(SYNC_ERR), 1);
            count_pv(5, cnt);
            check({tag, "_nopv"}, cnt, 0);
            check_outputs(tag);
        end
    endtask

    initial begin
        int cnt;
        int y0;
        logic [7:0] st, dx, dy, dz;

        mx = SX; my = SY; mz = 0; mbtn = 0;

        // Reset state
        tick(); tick(); tick();
        check("rst_x", int'(POS_X), SX);
        check("rst_y", int'(POS_Y), SY);
        check("rst_z", int'(POS_Z), 0);
        check("rst_btn", int'(BUTTONS), 0);
        check("rst_pv", int'(POS_VALID), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_ovr", int'(OVERRUN), 0);
        check("rst_serr", int'(SYNC_ERR), 0);
        RESET = 1'b0;
        tick();

        // Basic move
        send_pkt("basic", 8'h08, 8'h0A, 8'h05, 8'h00);
        check("basic_x_abs", int'(POS_X), 90);
        check("basic_y_abs", int'(POS_Y), 55);

        // Clamp at both X limits, back-to-back packets
        RECENTER = 1'b1; tick(); RECENTER = 1'b0;
        model_recenter();
        check("rc1_x", int'(POS_X), SX);
        send_pkt("neg", 8'h18, 8'h9C, 8'h00, 8'h00);
        check("neg_x_abs", int'(POS_X), 0);
        send_pkt("pos1", 8'h08, 8'h7F, 8'h00, 8'h00);
        send_pkt("pos2", 8'h08, 8'h7F, 8'h00, 8'h00);
        check("pos2_x_abs", int'(POS_X), LX - 1);

        // X overflow ignores X delta; sync error rejects
        y0 = int'(POS_Y);
        send_pkt("xovf", 8'h48, 8'hFF, 8'h03, 8'h00);
        check("xovf_x_abs", int'(POS_X), LX - 1);
        check("xovf_y_abs", int'(POS_Y), y0 - 3);
        send_pkt("sync", 8'h00, 8'h10, 8'h10, 8'h00);
        CLR_FLAGS = 1'b1; tick(); CLR_FLAGS = 1'b0;
        check("serr_clr", int'(SYNC_ERR), 0);

        // Overrun: second packet two cycles after the first
        drive_pkt(8'h09, 8'hFB, 8'h00, 8'h00);
        tick();
        PKT_VALID = 1'b0;
        tick();
        drive_pkt(8'h08, 8'h20, 8'h20, 8'h00);
        tick();
        PKT_VALID = 1'b0;
        count_pv(8, cnt);
        model_apply(8'h09, 8'hFB, 8'h00, 8'h00);
        check("ovr_pv_cnt", cnt, 1);
        check("ovr_flag", int'(OVERRUN), 1);
        check_outputs("ovr");
        CLR_FLAGS = 1'b1; tick(); CLR_FLAGS = 1'b0;
        check("ovr_clr", int'(OVERRUN), 0);

        // Set wins over simultaneous clear
        drive_pkt(8'h08, 8'h01, 8'h01, 8'h00);
        tick();
        CLR_FLAGS = 1'b1;
        tick();
        PKT_VALID = 1'b0; CLR_FLAGS = 1'b0;
        check("ovr_setwin", int'(OVERRUN), 1);
        count_pv(6, cnt);
        model_apply(8'h08, 8'h01, 8'h01, 8'h00);
        check("setwin_pv", cnt, 1);
        check_outputs("setwin");
        CLR_FLAGS = 1'b1; tick(); CLR_FLAGS = 1'b0;

        // Recenter during CALC
        drive_pkt(8'h08, 8'h30, 8'h30, 8'h00);
        tick();
        PKT_VALID = 1'b0;
        RECENTER = 1'b1;
        tick();
        RECENTER = 1'b0;
        model_recenter();
        check("rc_busy", int'(BUSY), 0);
        check("rc_x", int'(POS_X), SX);
        check("rc_y", int'(POS_Y), SY);
        count_pv(6, cnt);
        check("rc_nopv", cnt, 0);

        // Recenter beats simultaneous packet, no overrun
        drive_pkt(8'h08, 8'h05, 8'h05, 8'h00);
        RECENTER = 1'b1;
        tick();
        PKT_VALID = 1'b0; RECENTER = 1'b0;
        check("rcpk_busy", int'(BUSY), 0);
        check("rcpk_ovr", int'(OVERRUN), 0);
        count_pv(5, cnt);
        check("rcpk_nopv", cnt, 0);

        // Reset mid-packet
        drive_pkt(8'h08, 8'h10, 8'h10, 8'h00);
        tick();
        PKT_VALID = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        mx = SX; my = SY; mz = 0; mbtn = 0;
        count_pv(6, cnt);
        check("rstmid_nopv", cnt, 0);
        check_outputs("rstmid");

        // Wheel saturation
        for (int i = 0; i < 130; i++) begin
            send_pkt("wheel", 8'h08, 8'h00, 8'h00, 8'h01);
        end
`ifdef MOUSE_POS_WHEEL_EN
        check("wheel_sat", int'($signed(POS_Z)), 127);
`else
        check("wheel_off", int'($signed(POS_Z)), 0);
`endif

        // Randomized packets
        for (int i = 0; i < 60; i++) begin
            st = 8'($urandom);
            st[3] = ($urandom_range(0, 9) != 0);
            dx = 8'($urandom);
            dy = 8'($urandom);
            dz = 8'($urandom);
            send_pkt("rand", st, dx, dy, dz);
            if ($urandom_range(0, 15) == 0) begin
                RECENTER = 1'b1; tick(); RECENTER = 1'b0;
                model_recenter();
                check_outputs("rand_rc");
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
